if_network_ctrl: RTL and testbench
==================================

Name: if_network_ctrl

Overview:
- Inference sequencer for the IF spiking network.
- On start, it latches per-input intensities and pulses the network reset.
- It then drives rate-coded (LFSR-compared) spikes into the network for NUM_STEPS cycles and counts output spikes per neuron.
- It then scans the counts for the winning neuron and reports the result with a one-cycle done strobe.

Parameters:
- NUM_INPUTS, 4, number of network inputs / encoder channels
- NUM_OUTPUTS, 1, number of output neurons monitored
- NUM_STEPS, 64, presentation window length in clk cycles (>=1)
- DRAIN_CYCLES, 2, cycles after the window with inputs silent while counting continues (>=0)
- INTENSITY_BITS, 8, width of each input intensity
- COUNT_BITS, 8, width of each spike counter (saturating)
- LFSR_SEED, 16'hACE1, base seed; channel i seed = LFSR_SEED ^ (i+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin an inference; sampled only in IDLE
- intensity  in  NUM_INPUTS*INTENSITY_BITS  channel i at [i*INTENSITY_BITS +: INTENSITY_BITS]
- net_rst  out  1  reset to the network (drive its rst)
- spike_in_o  out  NUM_INPUTS  encoded spikes to network spike_in
- spike_out_i  in  NUM_OUTPUTS  network spike_out
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when results are valid
- spike_count  out  NUM_OUTPUTS*COUNT_BITS  per-neuron counts, held until next start
- winner  out  max(1,clog2(NUM_OUTPUTS))  index of the max count
- winner_valid  out  1  high with results when any count is nonzero

Behaviour:
- Clock/reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, spike_in_o=0, spike_count=0, winner=0, winner_valid=0; LFSRs = their seeds.
- net_rst = rst OR (state==CLEAR), so the network is reset along with the controller.
- FSM states: IDLE, CLEAR, RUN, DRAIN, ARGMAX, DONE.
- IDLE -> CLEAR when start=1.
  - Latch intensity.
  - Clear counters, winner and winner_valid.
  - Reload LFSRs to their seeds.
- CLEAR lasts exactly 1 cycle: net_rst=1, spike_in_o=0.
- RUN lasts exactly NUM_STEPS cycles, tracked by a step counter.
  - Each cycle, each channel's 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) advances once.
  - spike_in_o[i] = (lat_int[i] == all-ones) OR (lfsr_i[INTENSITY_BITS-1:0] < lat_int[i]), evaluated combinationally on the current LFSR value.
  - Intensity 0 never spikes; all-ones always spikes.
- DRAIN lasts DRAIN_CYCLES cycles with spike_in_o=0. If DRAIN_CYCLES=0, RUN goes directly to ARGMAX.
- Counting: in RUN and DRAIN, count[j] += spike_out_i[j] each cycle, saturating at 2^COUNT_BITS-1. No counting in any other state.
- ARGMAX lasts NUM_OUTPUTS cycles, examining one index per cycle in ascending order.
  - The running max is replaced only on a strictly greater count, so ties resolve to the lowest index.
- DONE lasts 1 cycle: done=1, winner_valid=(max>0), then -> IDLE.
  - If all counts are 0: winner=0, winner_valid=0.
- Latency: start sampled at edge k.
  - CLEAR in cycle k+1.
  - RUN in cycles k+2 .. k+1+NUM_STEPS.
  - done high in cycle k+2+NUM_STEPS+DRAIN_CYCLES+NUM_OUTPUTS.
- start while busy is ignored; no queuing.
- start asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- intensity changes after the start edge have no effect on the run in progress.
- Reset mid-run returns to IDLE on the next edge with all outputs at reset values and no done pulse.
- Results (spike_count, winner, winner_valid) remain stable from DONE until the next accepted start.

Test Plan:
- NUM_INPUTS=4, NUM_OUTPUTS=1, NUM_STEPS=64, DRAIN=2; tie spike_out_i to a model that spikes every cycle; pulse start at cycle 10 -> net_rst high only in cycle 11; done high only in cycle 79; spike_count=66 (64 RUN + 2 DRAIN); winner_valid=1.
- Intensities {FF,00,FF,00} -> spike_in_o = 4'b0101 on all 64 RUN cycles; 0 in CLEAR/DRAIN/IDLE. Intensity 80 on a channel -> spike count within 32±10 over 64 steps and bit-exact to the reference LFSR model.
- NUM_OUTPUTS=4; model spikes outputs at rates giving counts {5,12,12,3} -> winner=1 (tie resolves to lowest index), winner_valid=1. All-silent outputs -> winner=0, winner_valid=0, done still pulses.
- COUNT_BITS=4 with output constantly spiking -> count saturates at 15, no wrap.
- start re-pulsed at RUN step 20 -> ignored; done timing unchanged. rst asserted at RUN step 30 -> next cycle busy=0, outputs at reset values, no done. A fresh start then completes normally with identical LFSR sequence (seeds reloaded).
- Back-to-back: start held high continuously -> second run's CLEAR occurs 2 cycles after the first done; counts cleared at the second CLEAR.

Source files
------------

// File: rtl/if_network_ctrl.sv
// Inference sequencer for the IF spiking network: latches input intensities,
// resets the network, rate-codes spikes for a fixed window and reports the winner.
module if_network_ctrl #(
  parameter int NUM_INPUTS          = 4,
  parameter int NUM_OUTPUTS         = 1,
  parameter int NUM_STEPS           = 64,
  parameter int DRAIN_CYCLES        = 2,
  parameter int INTENSITY_BITS      = 8,
  parameter int COUNT_BITS          = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [NUM_INPUTS*INTENSITY_BITS-1:0]  intensity,
  output logic                                  net_rst,
  output logic [NUM_INPUTS-1:0]                 spike_in_o,
  input  logic [NUM_OUTPUTS-1:0]                spike_out_i,
  output logic                                  busy,
  output logic                                  done,
  output logic [NUM_OUTPUTS*COUNT_BITS-1:0]     spike_count,
  output logic [((NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1)-1:0] winner,
  output logic                                  winner_valid
);
  localparam int WW   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int MAXA = (NUM_STEPS > DRAIN_CYCLES) ? NUM_STEPS : DRAIN_CYCLES;
  localparam int MAXC = (MAXA > NUM_OUTPUTS) ? MAXA : NUM_OUTPUTS;
  localparam int SW   = $clog2(MAXC + 1);
  localparam logic [SW-1:0] LAST_STEP  = SW'(NUM_STEPS - 1);
  localparam logic [SW-1:0] LAST_DRAIN = (DRAIN_CYCLES > 0) ? SW'(DRAIN_CYCLES - 1) : '0;
  localparam logic [SW-1:0] LAST_SCAN  = SW'(NUM_OUTPUTS - 1);
  localparam logic [INTENSITY_BITS-1:0] INT_MAX = '1;
  localparam logic [COUNT_BITS-1:0]     CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, ARGMAX, DONE} state_t;

  state_t                 state_reg;
  logic [SW-1:0]          step_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic [WW-1:0]          winner_reg;
  logic                   valid_reg;
  logic [COUNT_BITS-1:0]  max_reg;
  logic [WW-1:0]          best_reg;
  logic [COUNT_BITS-1:0]  scan_count;
  logic                   scan_better;
  logic [COUNT_BITS-1:0]  max_next;
  logic [WW-1:0]          best_next;
  logic                   start_accept;
  logic                   counting;

  assign start_accept = (state_reg == IDLE) && start;
  assign counting     = (state_reg == RUN) || (state_reg == DRAIN);
  assign net_rst      = rst || (state_reg == CLEAR);
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign winner       = winner_reg;
  assign winner_valid = valid_reg;

  // Per-channel rate encoder: latched intensity compared against a private LFSR.
  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : ch_g
      localparam logic [15:0] CH_SEED = LFSR_SEED ^ 16'(gi + 1);
      logic [15:0]               lfsr_reg;
      logic [INTENSITY_BITS-1:0] lat_int_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          lfsr_reg    <= CH_SEED;
          lat_int_reg <= '0;
        end else if (start_accept) begin
          lfsr_reg    <= CH_SEED;
          lat_int_reg <= intensity[gi*INTENSITY_BITS +: INTENSITY_BITS];
        end else if (state_reg == RUN) begin
          lfsr_reg <= lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
        end
      end

      assign spike_in_o[gi] = (state_reg == RUN) &&
                              ((lat_int_reg == INT_MAX) ||
                               (lfsr_reg[INTENSITY_BITS-1:0] < lat_int_reg));
    end

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : out_g
      logic [COUNT_BITS-1:0] count_reg;

      always_ff @(posedge clk) begin
        if (rst || start_accept) begin
          count_reg <= '0;
        end else if (counting && spike_out_i[gi] && (count_reg != CNT_MAX)) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      assign spike_count[gi*COUNT_BITS +: COUNT_BITS] = count_reg;
    end
  endgenerate

  // During ARGMAX the step counter doubles as the neuron index being examined.
  always_comb begin
    scan_count = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (step_reg == SW'(j)) scan_count = spike_count[j*COUNT_BITS +: COUNT_BITS];
    end
  end

  assign scan_better = scan_count > max_reg;
  assign max_next    = scan_better ? scan_count : max_reg;
  assign best_next   = scan_better ? step_reg[WW-1:0] : best_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      winner_reg <= '0;
      valid_reg  <= 1'b0;
      max_reg    <= '0;
      best_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= CLEAR;
            busy_reg   <= 1'b1;
            winner_reg <= '0;
            valid_reg  <= 1'b0;
            max_reg    <= '0;
            best_reg   <= '0;
            step_reg   <= '0;
          end
        end
        CLEAR: begin
          state_reg <= RUN;
          step_reg  <= '0;
        end
        RUN: begin
          if (step_reg == LAST_STEP) begin
            step_reg  <= '0;
            state_reg <= (DRAIN_CYCLES > 0) ? DRAIN : ARGMAX;
          end else begin
            step_reg <= step_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (step_reg == LAST_DRAIN) begin
            step_reg  <= '0;
            state_reg <= ARGMAX;
          end else begin
            step_reg <= step_reg + 1'b1;
          end
        end
        ARGMAX: begin
          max_reg  <= max_next;
          best_reg <= best_next;
          if (step_reg == LAST_SCAN) begin
            state_reg  <= DONE;
            done_reg   <= 1'b1;
            winner_reg <= best_next;
            valid_reg  <= (max_next != '0);
          end else begin
            step_reg <= step_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_network_ctrl.sv
// Scoreboard bench for if_network_ctrl: a cycle-level reference model queues
// expectations, a monitor compares them against the DUT.
module tb_if_network_ctrl;
  localparam int NI = 4, NO = 4, NS = 64, DR = 2, IB = 8, CB = 8, SCB = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int T_DONE  = 2 + NS + DR + NO;
  localparam int T_SDONE = 2 + NS + DR + 1;
  localparam int WIN_END = 1 + NS + DR;
  localparam logic [SCB-1:0] SAT_MAX = '1;

  logic clk = 1'b0;
  logic rst, start, s_start;
  logic [NI*IB-1:0] intensity;
  logic net_rst, busy, done, winner_valid;
  logic [NI-1:0] spike_in_o;
  logic [NO-1:0] spike_out_i;
  logic [NO*CB-1:0] spike_count;
  logic [1:0] winner;
  logic s_net_rst, s_busy, s_done, s_valid;
  logic [NI-1:0] s_spike_in;
  logic [SCB-1:0] s_count;
  logic [0:0] s_winner;
  logic one_spike = 1'b1;

  always #5 clk = ~clk;

  if_network_ctrl #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .NUM_STEPS(NS), .DRAIN_CYCLES(DR),
                    .INTENSITY_BITS(IB), .COUNT_BITS(CB), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .intensity(intensity), .net_rst(net_rst),
    .spike_in_o(spike_in_o), .spike_out_i(spike_out_i), .busy(busy), .done(done),
    .spike_count(spike_count), .winner(winner), .winner_valid(winner_valid));

  // Single always-firing neuron with narrow counters to observe saturation.
  if_network_ctrl #(.NUM_INPUTS(NI), .NUM_OUTPUTS(1), .NUM_STEPS(NS), .DRAIN_CYCLES(DR),
                    .INTENSITY_BITS(IB), .COUNT_BITS(SCB), .LFSR_SEED(SEED)) sat_dut (
    .clk(clk), .rst(rst), .start(s_start), .intensity(intensity), .net_rst(s_net_rst),
    .spike_in_o(s_spike_in), .spike_out_i(one_spike), .busy(s_busy), .done(s_done),
    .spike_count(s_count), .winner(s_winner), .winner_valid(s_valid));

  typedef struct packed {
    logic net_rst, busy, done;
    logic [NI-1:0] spk;
    logic [NO*CB-1:0] cnt;
    logic [1:0] win;
    logic val;
    logic s_done;
    logic [SCB-1:0] s_cnt;
  } cyc_t;
  typedef struct packed {
    logic [NO*CB-1:0] cnt;
    logic [1:0] win;
    logic val;
  } res_t;

  cyc_t cyc_q[$];
  res_t res_q[$];
  int vectors = 0, miscompares = 0;

  int mcnt[NO];
  int scnt;
  int prob[NO];
  int quota[NO];
  logic [1:0] shown_win, pend_win;
  logic shown_val, pend_val;
  logic [IB-1:0] lat[NI];
  logic [15:0] mlfsr[NI];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [NO*CB-1:0] pack_cnt();
    logic [NO*CB-1:0] v;
    for (int j = 0; j < NO; j++) v[j*CB +: CB] = CB'(mcnt[j]);
    return v;
  endfunction

  task automatic clear_model();
    for (int j = 0; j < NO; j++) mcnt[j] = 0;
    scnt = 0;
    shown_win = '0;
    shown_val = 1'b0;
  endtask

  task automatic idle(input int n, input logic r);
    cyc_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst = r; start = 1'b0; s_start = 1'b0;
      intensity = $urandom();
      spike_out_i = NO'($urandom());
      e = '{net_rst: r, busy: 1'b0, done: 1'b0, spk: '0, cnt: pack_cnt(), win: shown_win,
            val: shown_val, s_done: 1'b0, s_cnt: SCB'(scnt)};
      cyc_q.push_back(e);
      if (r) clear_model();
    end
  endtask

  // One inference from the cycle start is presented (t=0) to DONE, or to an
  // aborting reset at t=abort_t.
  task automatic run(input logic [NI*IB-1:0] inten, input bit hold_start, input int abort_t);
    cyc_t e;
    logic [NO-1:0] so;
    bit in_win;
    int total, mx, best;
    total = (abort_t >= 0) ? abort_t : T_DONE;
    for (int t = 0; t <= total; t++) begin
      @(negedge clk);
      in_win = (t >= 2) && (t <= WIN_END);
      start = (t == 0) || (t == 22) || hold_start;
      s_start = (t == 0) || (t == 22);
      rst = (t == abort_t);
      intensity = (t == 0) ? inten : $urandom();
      for (int j = 0; j < NO; j++) begin
        if (quota[j] >= 0) so[j] = in_win ? (mcnt[j] < quota[j]) : 1'($urandom());
        else so[j] = ($urandom_range(99) < prob[j]);
      end
      spike_out_i = so;
      e.net_rst = (t == 1) || (t == abort_t);
      e.busy = (t >= 1);
      e.done = (t == T_DONE);
      e.spk = '0;
      if (t >= 2 && t <= 1 + NS)
        for (int i = 0; i < NI; i++) e.spk[i] = (lat[i] == 8'hFF) || (mlfsr[i][IB-1:0] < lat[i]);
      e.cnt = pack_cnt();
      e.win = shown_win;
      e.val = shown_val;
      e.s_done = (t == T_SDONE);
      e.s_cnt = SCB'(scnt);
      cyc_q.push_back(e);

      if (t == 0) begin
        for (int i = 0; i < NI; i++) begin
          lat[i] = inten[i*IB +: IB];
          mlfsr[i] = SEED ^ 16'(i + 1);
        end
        clear_model();
      end
      if (t >= 2 && t <= 1 + NS)
        for (int i = 0; i < NI; i++) mlfsr[i] = lfsr_step(mlfsr[i]);
      if (in_win) begin
        for (int j = 0; j < NO; j++) if (so[j] && mcnt[j] < 255) mcnt[j]++;
        if (scnt < 15) scnt++;
      end
      if (t == WIN_END) begin
        mx = 0; best = 0;
        for (int j = 0; j < NO; j++) if (mcnt[j] > mx) begin mx = mcnt[j]; best = j; end
        pend_win = 2'(best);
        pend_val = (mx > 0);
        res_q.push_back('{cnt: pack_cnt(), win: pend_win, val: pend_val});
      end
      if (t == T_DONE - 1) begin
        shown_win = pend_win;
        shown_val = pend_val;
      end
      if (t == abort_t) clear_model();
    end
  endtask

  task automatic set_probs(input int p);
    for (int j = 0; j < NO; j++) begin
      prob[j] = p;
      quota[j] = -1;
    end
  endtask

  task automatic random_probs();
    for (int j = 0; j < NO; j++) begin
      prob[j] = $urandom_range(100);
      quota[j] = ($urandom_range(3) == 0) ? int'($urandom_range(66)) : -1;
    end
  endtask

  initial begin : monitor
    cyc_t e;
    res_t r;
    forever begin
      @(negedge clk);
      #1;
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        check("net_rst", 64'(net_rst), 64'(e.net_rst));
        check("busy", 64'(busy), 64'(e.busy));
        check("done", 64'(done), 64'(e.done));
        check("spike_in_o", 64'(spike_in_o), 64'(e.spk));
        check("spike_count", 64'(spike_count), 64'(e.cnt));
        check("winner", 64'(winner), 64'(e.win));
        check("winner_valid", 64'(winner_valid), 64'(e.val));
        check("sat_done", 64'(s_done), 64'(e.s_done));
        check("sat_count", 64'(s_count), 64'(e.s_cnt));
      end
      if (done === 1'b1) begin
        if (res_q.size() == 0) begin
          check("done_unexpected", 64'(done), 64'(0));
        end else begin
          r = res_q.pop_front();
          check("result_counts", 64'(spike_count), 64'(r.cnt));
          check("result_winner", 64'(winner), 64'(r.win));
          check("result_valid", 64'(winner_valid), 64'(r.val));
        end
      end
      if (s_done === 1'b1) begin
        check("sat_final_count", 64'(s_count), 64'(SAT_MAX));
        check("sat_valid", 64'(s_valid), 64'(1));
        check("sat_winner", 64'(s_winner), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    logic [NI*IB-1:0] saved;
    rst = 1'b1; start = 1'b0; s_start = 1'b0; intensity = '0; spike_out_i = '0;
    set_probs(50);
    clear_model();
    pend_win = '0; pend_val = 1'b0;
    repeat (3) @(negedge clk);
    idle(1, 1'b1);
    idle(3, 1'b0);

    set_probs(100);
    run(32'h00FF00FF, 1'b0, -1);
    idle(2, 1'b0);

    set_probs(0);
    quota[0] = 5; quota[1] = 12; quota[2] = 12; quota[3] = 3;
    run(32'h2080C4FE, 1'b0, -1);
    idle(2, 1'b0);

    set_probs(0);
    run($urandom(), 1'b0, -1);
    idle(2, 1'b0);

    random_probs();
    saved = $urandom();
    run(saved, 1'b0, 32);
    idle(2, 1'b0);
    run(saved, 1'b0, -1);
    idle(1, 1'b0);

    random_probs();
    run($urandom(), 1'b1, -1);
    random_probs();
    run($urandom(), 1'b0, -1);
    idle(2, 1'b0);

    for (int k = 0; k < 4; k++) begin
      random_probs();
      run($urandom(), 1'($urandom_range(1)), -1);
      idle($urandom_range(3), 1'b0);
    end

    idle(3, 1'b0);
    check("results_reported", 64'(res_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
